// File: rtl/fir_decim_fifo.sv
// Decimate, round/saturate 16-bit filter samples to 8 bits, buffer in a FWFT FIFO; 2 edges accept-to-out_valid.
// No input backpressure: a kept sample that finds the FIFO full (and no pop) is dropped and flagged sticky.
module fir_decim_fifo #(
  parameter int DECIM = 2,
  parameter int SHIFT = 4,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [15:0]        y_in,
  input  logic                      in_valid,
  output logic signed [7:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int HALF = 1 << (SHIFT - 1);

  logic [PW-1:0]        phase;
  logic                 keep;
  logic signed [16:0]   rounded;
  logic signed [16:0]   shifted;
  logic signed [7:0]    scaled;

  logic                 stage_vld;
  logic signed [7:0]    stage_dat;

  logic signed [7:0]    mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign keep    = in_valid && (phase == '0);
  assign rounded = {y_in[15], y_in} + 17'(HALF);
  assign shifted = rounded >>> SHIFT;

  always_comb begin
    scaled = shifted[7:0];
    if (shifted > 17'sd127)
      scaled = 8'sd127;
    else if (shifted < -17'sd128)
      scaled = -8'sd128;
  end

  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  // A pop frees the head slot on the same edge, so a full FIFO still takes the stage sample.
  assign push      = stage_vld && (!full || pop);
  assign drop      = stage_vld && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      stage_vld <= 1'b0;
      stage_dat <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (in_valid)
        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
      stage_vld <= keep;
      if (keep)
        stage_dat <= scaled;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= stage_dat;
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Randomized and directed bench for fir_decim_fifo with a queue-based reference model.
module tb_fir_decim_fifo;
  localparam int DECIM = 2;
  localparam int SHIFT = 4;
  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] y_in = '0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic               overflow;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int mq[$];
  int m_stage;
  bit m_stage_vld = 0;
  int m_phase = 0;
  bit m_ovf = 0;

  int got[$];
  int expv[$];

  fir_decim_fifo #(.DECIM(DECIM), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // round half up with floor division, then clamp to the signed byte range
  function automatic int mscale(input int v);
    int t, d, r;
    d = 1 << SHIFT;
    t = v + (1 << (SHIFT - 1));
    if (t >= 0) r = t / d;
    else        r = -((-t + d - 1) / d);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_stage_vld = 0;
      m_phase = 0;
      m_ovf = 0;
    end else begin
      bit pop_now, full_now;
      pop_now  = (mq.size() != 0) && out_ready;
      full_now = (mq.size() == DEPTH);
      if (pop_now) void'(mq.pop_front());
      if (m_stage_vld) begin
        if (full_now && !pop_now) m_ovf = 1;
        else mq.push_back(m_stage);
      end
      m_stage_vld = in_valid && (m_phase == 0);
      m_stage = mscale(int'(y_in));
      if (in_valid) m_phase = (m_phase + 1) % DECIM;
    end
  end

  // inputs change just after posedge, so negedge sees a settled state
  always @(negedge clk) begin
    chk("level", 32'(level), mq.size());
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", $signed(out_data), mq[0]);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (reset && out_valid && out_ready) got.push_back(int'($signed(out_data)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    got.delete();
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got.size(), expv.size());
    for (int i = 0; i < expv.size() && i < got.size(); i++)
      chk(name, got[i], expv[i]);
  endtask

  initial begin
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    repeat (2) step();
    reset = 1'b1;
    step();

    // single sample: latency and rounding
    do_reset();
    out_ready = 1'b1;
    y_in = 16'sd100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_e0_valid", 32'(out_valid), 0);
    step();
    chk("lat_e1_valid", 32'(out_valid), 1);
    chk("lat_e1_data", $signed(out_data), 6);
    step();
    chk("lat_e2_valid", 32'(out_valid), 0);
    idle(2);
    expv = '{6};
    check_got("latency");

    // decimation by two
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      y_in = 16'(16 * i);
      step();
    end
    idle(4);
    expv = '{1, 3};
    check_got("decim");

    // saturation and negative rounding, each kept sample followed by a discarded one
    do_reset();
    out_ready = 1'b1;
    begin
      int vals[4] = '{32767, -32768, -24, -25};
      for (int i = 0; i < 4; i++) begin
        y_in = 16'(vals[i]); in_valid = 1'b1;
        step();
        y_in = 16'($urandom);
        step();
      end
    end
    idle(4);
    expv = '{127, -128, -1, -2};
    check_got("sat");

    // overflow with a stalled consumer
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      y_in = 16'(16 * k);
      step();
    end
    idle(2);
    chk("ovf_level", 32'(level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_model_size", mq.size(), 8);
    chk("ovf_model_head", mq[0], 0);
    chk("ovf_model_tail", mq[7], 14);
    out_ready = 1'b1;
    idle(10);
    expv = '{0, 2, 4, 6, 8, 10, 12, 14};
    check_got("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 1);

    // push and pop on the same edge while full
    do_reset();
    for (int i = 0; i < 32; i++) begin
      y_in = 16'(16 * i); in_valid = 1'b1;
      out_ready = (i >= 16) && (i % 2 == 1);
      step();
      if (i >= 16) begin
        chk("full_level", 32'(level), 8);
        chk("full_noovf", 32'(overflow), 0);
      end
    end
    out_ready = 1'b1;
    idle(12);
    expv.delete();
    for (int i = 0; i < 16; i++) expv.push_back(2 * i);
    check_got("full_order");
    chk("full_end_ovf", 32'(overflow), 0);

    // reset between edges with five entries buffered and phase left at one
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      y_in = 16'(16 * i);
      step();
    end
    idle(2);
    chk("mid_level_pre", 32'(level), 5);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_level", 32'(level), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", $signed(out_data), 0);
    repeat (2) step();
    reset = 1'b1;
    got.delete();
    out_ready = 1'b1;
    y_in = 16'sd160; in_valid = 1'b1;
    step();
    idle(4);
    expv = '{10};
    check_got("mid_first");

    // randomized traffic, checked every cycle against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      y_in      = 16'($urandom);
      out_ready = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 80));
      step();
    end
    out_ready = 1'b1;
    idle(12);
    chk("rand_drained", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
